app_switcher: RTL and testbench
===============================

# app_switcher

Parametrised application switcher for the Basys3 OLED/seven-segment platform. It replaces the fixed four-way state controller and output mux with one block that owns the menu cursor, runs a launch/ready/exit handshake with each of N application slots, blanks the OLED between applications, and drives registered OLED pixel, anode and segment outputs. It sits between the per-application display modules and the `Oled_Display` and seven-segment pins.

## Interface
- `N_APPS`, 4, number of application slots (2..8)
- `READY_TIMEOUT`, 1000, `clk` cycles to wait for `app_ready` after launch
- `BLANK_FRAMES`, 2, OLED frames forced black on exit
- `IDX_W`, `$clog2(N_APPS)`, cursor width (derived, not overridden)

Ports:
- `clk` in 1: system clock, 1 kHz button-pulse domain
- `rst` in 1: asynchronous, active-low reset
- `btn_up`, `btn_down`, `btn_c` in 1 each: single-cycle button pulses
- `frame_begin` in 1: OLED frame strobe, pre-synchronised to `clk`
- `app_ready` in N_APPS: slot finished initialisation (level)
- `app_done` in N_APPS: slot requests exit (level or pulse)
- `menu_oled` in 16: menu pixel
- `app_oled` in 16*N_APPS: slot pixels, slot k at [16k+15:16k]
- `menu_an`/`app_an` in 4 / 4*N_APPS: anodes, active-low
- `menu_seg`/`app_seg` in 8 / 8*N_APPS: segments, active-low
- `oled_data` out 16: registered pixel
- `an` out 4, `seg` out 8: registered seven-segment drive
- `app_en` out N_APPS: one-hot run enable
- `app_start` out N_APPS: one-cycle launch pulse
- `cursor` out IDX_W: highlighted menu entry
- `sw_state` out 2: MENU=0, LAUNCH=1, RUN=2, EXIT=3
- `launch_err` out 1: sticky timeout flag

## Operation
- MENU: `btn_up` decrements `cursor` and `btn_down` increments it, saturating at 0 and N_APPS-1. `btn_c` moves to LAUNCH for slot `cursor`, clears `launch_err`, and pulses `app_start[cursor]` for one cycle.
- LAUNCH: `app_en[sel]`=1. `app_ready[sel]` moves to RUN. If the timeout counter reaches READY_TIMEOUT-1 first, set `launch_err`, drop `app_en`, and return to MENU.
- RUN: outputs come from slot `sel`. `app_done[sel]` moves to EXIT. Buttons are ignored by the switcher and pass through to the application.
- EXIT: `app_en`=0. Output black/blank until BLANK_FRAMES `frame_begin` strobes are counted, then return to MENU. `cursor` keeps its value.
- Output source: MENU → menu inputs; LAUNCH/EXIT → `oled_data`=0, `an`=4'hF, `seg`=8'hFF; RUN → slot `sel`.
- `app_done`/`app_ready` of non-selected slots are ignored.
- Simultaneous `btn_up`+`btn_down`: no cursor change. `btn_c` in the same cycle as either: launch wins, cursor unchanged.
- `app_done[sel]` during LAUNCH is ignored. It is re-evaluated in RUN.

## Timing
- Reset (async assert, sync release): `sw_state`=MENU, `cursor`=0, `app_en`=0, `app_start`=0, `launch_err`=0, `oled_data`=0, `an`=4'hF, `seg`=8'hFF. All counters are 0.
- Reset mid-RUN: `app_en` drops immediately and asynchronously.
- Output mux latency: 1 cycle from input change to `oled_data`/`an`/`seg`.
- `btn_c` at edge t: `sw_state`=LAUNCH and `app_start` high during cycle t+1 only.
- `app_ready` sampled at edge t: RUN from t+1.
- Timeout: LAUNCH lasts exactly READY_TIMEOUT cycles.
- EXIT: a `frame_begin` coincident with entry is not counted.

## Configuration
- `APP_SWITCHER_WRAP_EN` defined: cursor wraps (0 −1 → N_APPS-1, N_APPS-1 +1 → 0).
- Undefined: cursor saturates as described above.

## Structure
- `app_switcher_pkg`: state enum `sw_state_t`, blank constants `OLED_BLACK`=16'h0000, `AN_OFF`=4'hF, `SEG_OFF`=8'hFF.
- Sub-module `app_output_mux`: registered N+1-way mux for pixel/anode/segment with a force-blank input. The FSM, cursor and counters stay in `app_switcher`.

## Test plan
- Reset, then three `btn_down` pulses with N_APPS=4 → `cursor`=3. A fourth pulse → 3 (0 with WRAP_EN).
- `cursor`=2, `btn_c` → `app_start`=4'b0100 for one cycle, `app_en`=4'b0100. `app_ready[2]` after 5 cycles → RUN, and `oled_data` equals `app_oled[47:32]` one cycle later.
- LAUNCH with no `app_ready`, READY_TIMEOUT=10 → MENU after 10 cycles, `launch_err`=1, `app_en`=0.
- RUN slot 1, assert `app_done[1]` → `app_en`=0 and `oled_data`=0 across 2 `frame_begin` strobes, then MENU with `cursor`=1.
- RUN slot 0 with `app_done[3]`=1 → remains RUN. `btn_up`+`btn_down` together in MENU → `cursor` unchanged.
- Assert `rst`=0 during RUN → `app_en`=0 and `an`=4'hF without a clock edge.

Source files
------------

// File: rtl/app_switcher_pkg.sv
// Shared state encoding and blank-output constants for the application switcher.
package app_switcher_pkg;

  typedef enum logic [1:0] {
    SW_MENU   = 2'd0,
    SW_LAUNCH = 2'd1,
    SW_RUN    = 2'd2,
    SW_EXIT   = 2'd3
  } sw_state_t;

  localparam logic [15:0] OLED_BLACK = 16'h0000;
  localparam logic [3:0]  AN_OFF     = 4'hF;
  localparam logic [7:0]  SEG_OFF    = 8'hFF;

endpackage

// File: rtl/app_output_mux.sv
// Registered (N_APPS+1)-way pixel/anode/segment mux with a force-blank override.
module app_output_mux
  import app_switcher_pkg::*;
#(
  parameter  int N_APPS = 4,
  localparam int IDX_W  = $clog2(N_APPS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   blank_i,
  input  logic                   app_sel_i,
  input  logic [IDX_W-1:0]       sel_i,
  input  logic [15:0]            menu_oled_i,
  input  logic [N_APPS-1:0][15:0] app_oled_i,
  input  logic [3:0]             menu_an_i,
  input  logic [N_APPS-1:0][3:0] app_an_i,
  input  logic [7:0]             menu_seg_i,
  input  logic [N_APPS-1:0][7:0] app_seg_i,
  output logic [15:0]            oled_o,
  output logic [3:0]             an_o,
  output logic [7:0]             seg_o
);

  logic [15:0] oled_d;
  logic [3:0]  an_d;
  logic [7:0]  seg_d;

  always_comb begin
    oled_d = menu_oled_i;
    an_d   = menu_an_i;
    seg_d  = menu_seg_i;
    if (blank_i) begin
      oled_d = OLED_BLACK;
      an_d   = AN_OFF;
      seg_d  = SEG_OFF;
    end else if (app_sel_i) begin
      oled_d = app_oled_i[sel_i];
      an_d   = app_an_i[sel_i];
      seg_d  = app_seg_i[sel_i];
    end
  end

  // Reset value is the blank pattern so the panel stays dark until the first edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oled_o <= OLED_BLACK;
      an_o   <= AN_OFF;
      seg_o  <= SEG_OFF;
    end else begin
      oled_o <= oled_d;
      an_o   <= an_d;
      seg_o  <= seg_d;
    end
  end

endmodule

// File: rtl/app_switcher.sv
// Menu cursor, launch/ready/exit handshake and output blanking for N application slots.
// Define APP_SWITCHER_WRAP_EN to make the cursor wrap instead of saturate.
module app_switcher
  import app_switcher_pkg::*;
#(
  parameter  int N_APPS        = 4,
  parameter  int READY_TIMEOUT = 1000,
  parameter  int BLANK_FRAMES  = 2,
  localparam int IDX_W         = $clog2(N_APPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_c,
  input  logic                  frame_begin,
  input  logic [N_APPS-1:0]     app_ready,
  input  logic [N_APPS-1:0]     app_done,
  input  logic [15:0]           menu_oled,
  input  logic [16*N_APPS-1:0]  app_oled,
  input  logic [3:0]            menu_an,
  input  logic [4*N_APPS-1:0]   app_an,
  input  logic [7:0]            menu_seg,
  input  logic [8*N_APPS-1:0]   app_seg,
  output logic [15:0]           oled_data,
  output logic [3:0]            an,
  output logic [7:0]            seg,
  output logic [N_APPS-1:0]     app_en,
  output logic [N_APPS-1:0]     app_start,
  output logic [IDX_W-1:0]      cursor,
  output logic [1:0]            sw_state,
  output logic                  launch_err
);

  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam int FW = $clog2(BLANK_FRAMES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_APPS - 1);

  sw_state_t         state_q, state_d;
  logic [IDX_W-1:0]  cursor_q, cursor_d, sel_q, sel_d, cur_inc, cur_dec;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [FW-1:0]     frm_q, frm_d;
  logic              err_q, err_d;
  logic [N_APPS-1:0] start_q, start_d;

`ifdef APP_SWITCHER_WRAP_EN
  assign cur_dec = (cursor_q == '0)   ? LAST : cursor_q - IDX_W'(1);
  assign cur_inc = (cursor_q == LAST) ? '0   : cursor_q + IDX_W'(1);
`else
  assign cur_dec = (cursor_q == '0)   ? '0   : cursor_q - IDX_W'(1);
  assign cur_inc = (cursor_q == LAST) ? LAST : cursor_q + IDX_W'(1);
`endif

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    sel_d    = sel_q;
    err_d    = err_q;
    tmo_d    = '0;
    frm_d    = '0;
    start_d  = '0;
    unique case (state_q)
      SW_MENU: begin
        // Launch takes priority over any cursor movement in the same cycle.
        if (btn_c) begin
          state_d = SW_LAUNCH;
          sel_d   = cursor_q;
          err_d   = 1'b0;
          start_d = N_APPS'(1) << cursor_q;
        end else if (btn_up && !btn_down) begin
          cursor_d = cur_dec;
        end else if (btn_down && !btn_up) begin
          cursor_d = cur_inc;
        end
      end
      SW_LAUNCH: begin
        if (app_ready[sel_q]) begin
          state_d = SW_RUN;
        end else if (tmo_q == TW'(READY_TIMEOUT - 1)) begin
          state_d = SW_MENU;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      SW_RUN: begin
        if (app_done[sel_q]) state_d = SW_EXIT;
      end
      SW_EXIT: begin
        // frm_q is zero on entry, so a strobe on the entry edge was never seen here.
        frm_d = frm_q;
        if (frame_begin) begin
          if (frm_q == FW'(BLANK_FRAMES - 1)) state_d = SW_MENU;
          else                                frm_d   = frm_q + FW'(1);
        end
      end
      default: state_d = SW_MENU;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SW_MENU;
      cursor_q <= '0;
      sel_q    <= '0;
      tmo_q    <= '0;
      frm_q    <= '0;
      err_q    <= 1'b0;
      start_q  <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      sel_q    <= sel_d;
      tmo_q    <= tmo_d;
      frm_q    <= frm_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

  // Decoded from the state register so reset removes the enable without a clock.
  assign app_en     = (state_q == SW_LAUNCH || state_q == SW_RUN) ? (N_APPS'(1) << sel_q) : '0;
  assign app_start  = start_q;
  assign cursor     = cursor_q;
  assign sw_state   = state_q;
  assign launch_err = err_q;

  app_output_mux #(.N_APPS(N_APPS)) u_mux (
    .clk_i       (clk),
    .rst_ni      (rst),
    .blank_i     (state_q == SW_LAUNCH || state_q == SW_EXIT),
    .app_sel_i   (state_q == SW_RUN),
    .sel_i       (sel_q),
    .menu_oled_i (menu_oled),
    .app_oled_i  (app_oled),
    .menu_an_i   (menu_an),
    .app_an_i    (app_an),
    .menu_seg_i  (menu_seg),
    .app_seg_i   (app_seg),
    .oled_o      (oled_data),
    .an_o        (an),
    .seg_o       (seg)
  );

endmodule

// File: tb/tb_app_switcher.sv
// Directed and randomized checks of app_switcher against a cycle-level behavioural model.
module tb_app_switcher;

  localparam int N  = 4;
  localparam int RT = 10;
  localparam int BF = 2;
`ifdef APP_SWITCHER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_c = 1'b0, frame_begin = 1'b0;
  logic [N-1:0]    app_ready = '0, app_done = '0;
  logic [15:0]     menu_oled;
  logic [16*N-1:0] app_oled;
  logic [3:0]      menu_an;
  logic [4*N-1:0]  app_an;
  logic [7:0]      menu_seg;
  logic [8*N-1:0]  app_seg;
  logic [15:0]     oled_data;
  logic [3:0]      an;
  logic [7:0]      seg;
  logic [N-1:0]    app_en, app_start;
  logic [1:0]      cursor;
  logic [1:0]      sw_state;
  logic            launch_err;

  int n_chk = 0, n_err = 0;

  // model: mode 0=menu 1=launch 2=run 3=exit
  int          m_mode, m_cur, m_sel, m_tmo, m_frm, m_err;
  logic [N-1:0] m_start;
  logic [15:0] e_oled;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;

  app_switcher #(.N_APPS(N), .READY_TIMEOUT(RT), .BLANK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_c(btn_c),
    .frame_begin(frame_begin), .app_ready(app_ready), .app_done(app_done),
    .menu_oled(menu_oled), .app_oled(app_oled), .menu_an(menu_an), .app_an(app_an),
    .menu_seg(menu_seg), .app_seg(app_seg), .oled_data(oled_data), .an(an), .seg(seg),
    .app_en(app_en), .app_start(app_start), .cursor(cursor), .sw_state(sw_state),
    .launch_err(launch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_sel = 0; m_tmo = 0; m_frm = 0; m_err = 0;
    m_start = '0; e_oled = 16'h0; e_an = 4'hF; e_seg = 8'hFF;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    if (m_mode == 0) begin
      e_oled = menu_oled; e_an = menu_an; e_seg = menu_seg;
    end else if (m_mode == 2) begin
      e_oled = app_oled[16*m_sel +: 16]; e_an = app_an[4*m_sel +: 4]; e_seg = app_seg[8*m_sel +: 8];
    end else begin
      e_oled = 16'h0; e_an = 4'hF; e_seg = 8'hFF;
    end
    m_start = '0;
    case (m_mode)
      0: if (btn_c) begin
           m_mode = 1; m_sel = m_cur; m_err = 0; m_tmo = 0; m_start = N'(1) << m_cur;
         end else if (btn_up && !btn_down) begin
           m_cur = (m_cur == 0) ? (WRAP ? N-1 : 0) : m_cur - 1;
         end else if (btn_down && !btn_up) begin
           m_cur = (m_cur == N-1) ? (WRAP ? 0 : N-1) : m_cur + 1;
         end
      1: if (app_ready[m_sel]) m_mode = 2;
         else begin
           m_tmo++;
           if (m_tmo == RT) begin m_mode = 0; m_err = 1; end
         end
      2: if (app_done[m_sel]) begin m_mode = 3; m_frm = 0; end
      3: if (frame_begin) begin
           m_frm++;
           if (m_frm == BF) m_mode = 0;
         end
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [N-1:0] e_en;
    e_en = (m_mode == 1 || m_mode == 2) ? (N'(1) << m_sel) : '0;
    chk("sw_state",   32'(sw_state),   m_mode);
    chk("cursor",     32'(cursor),     m_cur);
    chk("app_en",     32'(app_en),     32'(e_en));
    chk("app_start",  32'(app_start),  32'(m_start));
    chk("launch_err", 32'(launch_err), m_err);
    chk("oled_data",  32'(oled_data),  32'(e_oled));
    chk("an",         32'(an),         32'(e_an));
    chk("seg",        32'(seg),        32'(e_seg));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      menu_oled = 16'($urandom); menu_an = 4'($urandom); menu_seg = 8'($urandom);
      for (int k = 0; k < N; k++) begin
        app_oled[16*k +: 16] = 16'($urandom);
        app_an[4*k +: 4]     = 4'($urandom);
        app_seg[8*k +: 8]    = 8'($urandom);
      end
      model_step();
      @(posedge clk); #1;
      check_all();
      btn_up = 1'b0; btn_down = 1'b0; btn_c = 1'b0; frame_begin = 1'b0;
    end
  endtask

  initial begin
    menu_oled = '0; menu_an = '0; menu_seg = '0; app_oled = '0; app_an = '0; app_seg = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst = 1'b1;
    step(2);

    // cursor walk and saturation/wrap
    repeat (3) begin btn_down = 1'b1; step(1); end
    chk("cur_after3", 32'(cursor), 3);
    btn_down = 1'b1; step(1);
`ifdef APP_SWITCHER_WRAP_EN
    chk("cur_wrap", 32'(cursor), 0);
    btn_up = 1'b1; step(1);
`else
    chk("cur_sat", 32'(cursor), 3);
`endif
    btn_up = 1'b1; step(1);
    chk("cur2", 32'(cursor), 2);
    btn_up = 1'b1; btn_down = 1'b1; step(1);
    chk("updown_hold", 32'(cursor), 2);

    // launch slot 2, ready after 5 cycles, done during launch ignored
    btn_c = 1'b1; btn_up = 1'b1; step(1);
    chk("start_2", 32'(app_start), 32'h4);
    chk("en_2", 32'(app_en), 32'h4);
    app_ready = 4'b0001; app_done = 4'b0100;
    step(3);
    app_done = '0;
    step(1);
    app_ready = 4'b0101; step(1);
    chk("run_2", 32'(sw_state), 2);
    app_ready = '0;
    step(1);
    chk("oled_slot2", 32'(oled_data), 32'(app_oled[47:32]));

    // foreign done ignored, then exit with a strobe on the entry edge
    app_done = 4'b1000; step(3);
    chk("run_foreign_done", 32'(sw_state), 2);
    app_done = 4'b0100; frame_begin = 1'b1; step(1);
    app_done = '0;
    chk("exit", 32'(sw_state), 3);
    step(2);
    frame_begin = 1'b1; step(1);
    chk("exit_1frame", 32'(sw_state), 3);
    step(3);
    frame_begin = 1'b1; step(1);
    chk("back_menu", 32'(sw_state), 0);

    // timeout
    btn_c = 1'b1; step(1);
    step(RT-1);
    chk("launch_last", 32'(sw_state), 1);
    step(1);
    chk("tmo_err", 32'(launch_err), 1);
    chk("tmo_en", 32'(app_en), 0);

    // slot 1: launch, run, exit, cursor kept
    btn_up = 1'b1; step(1);
    btn_c = 1'b1; step(1);
    chk("err_clear", 32'(launch_err), 0);
    app_ready = 4'b0010; step(1);
    app_ready = '0; step(2);
    app_done = 4'b0010; step(1);
    app_done = '0;
    chk("exit_en", 32'(app_en), 0);
    for (int f = 0; f < BF; f++) begin step(2); frame_begin = 1'b1; step(1); end
    chk("menu_cur1", 32'(cursor), 1);

    // async reset in run
    btn_c = 1'b1; step(1);
    app_ready = 4'b0010; step(1);
    app_ready = '0; step(2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_en", 32'(app_en), 0);
    chk("async_an", 32'(an), 32'hF);
    chk("async_state", 32'(sw_state), 0);
    @(negedge clk) rst = 1'b1;
    step(1);

    // randomized traffic
    repeat (3000) begin
      btn_up      = ($urandom_range(0, 7) == 0);
      btn_down    = ($urandom_range(0, 7) == 0);
      btn_c       = ($urandom_range(0, 11) == 0);
      frame_begin = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        app_ready[k] = ($urandom_range(0, 9) == 0);
        app_done[k]  = ($urandom_range(0, 7) == 0);
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
